// File: rtl/pla_lookup_arbiter.sv
// Round-robin front end that shares one combinational PLA among NUM_REQ requesters.
// One lookup is in flight at a time. The result is captured after a settle delay and returned on a valid/ready channel.
module pla_lookup_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int IN_W          = 8,
  parameter int OUT_W         = 63,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*IN_W-1:0]   req_x,
  output logic [IN_W-1:0]           pla_x,
  input  logic [OUT_W-1:0]          pla_z,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUT_W-1:0]          rsp_z,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          lookup_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IN_W-1:0]    pla_x_q, pla_x_d;
  logic [OUT_W-1:0]   rsp_z_q, rsp_z_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   lookup_cnt_q, lookup_cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  int                 idx;

  // Rotating priority: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    grant[gnt_idx] = gnt_any;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    pla_x_d      = pla_x_q;
    rsp_z_d      = rsp_z_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    lookup_cnt_d = lookup_cnt_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (gnt_any) begin
          pla_x_d  = req_x[gnt_idx*IN_W +: IN_W];
          rsp_id_d = gnt_idx;
          rr_ptr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
          cnt_d    = 4'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_z_d     = pla_z;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Completion always returns to IDLE, leaving one bubble before the next grant.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (lookup_cnt_q != {CNT_W{1'b1}}) lookup_cnt_d = lookup_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      pla_x_q      <= '0;
      rsp_z_q      <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      lookup_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      pla_x_q      <= pla_x_d;
      rsp_z_q      <= rsp_z_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      lookup_cnt_q <= lookup_cnt_d;
    end
  end

  assign pla_x      = pla_x_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = (state_q != IDLE);
  assign lookup_cnt = lookup_cnt_q;

endmodule

// File: tb/tb_pla_lookup_arbiter.sv
// Directed bench for pla_lookup_arbiter: a default instance plus settle=0, settle=15 and 4-bit-counter variants.
module tb_pla_lookup_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [62:0] pla_model(input logic [7:0] x);
    return {x[6:0], ~x, x, x ^ 8'hA5, ~x, x, x ^ 8'h3C, ~x};
  endfunction

  // main instance (SETTLE_CYCLES=1, CNT_W=16)
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_x;
  logic [7:0]  pla_x;
  logic [62:0] pla_z, rsp_z;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [15:0] lookup_cnt;
  assign pla_z = pla_model(pla_x);

  pla_lookup_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .pla_x(pla_x), .pla_z(pla_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .busy(busy), .lookup_cnt(lookup_cnt));

  // settle-time variants share stimulus
  logic [3:0]  a_valid;
  logic [31:0] a_x;
  logic        a_ready;
  logic [3:0]  s0_rdy, s15_rdy;
  logic [7:0]  s0_pla_x, s15_pla_x;
  logic [62:0] s0_pla_z, s15_pla_z, s0_rsp_z, s15_rsp_z;
  logic        s0_rsp_valid, s15_rsp_valid, s0_busy, s15_busy;
  logic [1:0]  s0_rsp_id, s15_rsp_id;
  logic [15:0] s0_cnt, s15_cnt;
  assign s0_pla_z  = pla_model(s0_pla_x);
  assign s15_pla_z = pla_model(s15_pla_x);

  pla_lookup_arbiter #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(s0_rdy), .req_x(a_x),
    .pla_x(s0_pla_x), .pla_z(s0_pla_z), .rsp_valid(s0_rsp_valid), .rsp_ready(a_ready),
    .rsp_z(s0_rsp_z), .rsp_id(s0_rsp_id), .busy(s0_busy), .lookup_cnt(s0_cnt));

  pla_lookup_arbiter #(.SETTLE_CYCLES(15)) u_s15 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(s15_rdy), .req_x(a_x),
    .pla_x(s15_pla_x), .pla_z(s15_pla_z), .rsp_valid(s15_rsp_valid), .rsp_ready(a_ready),
    .rsp_z(s15_rsp_z), .rsp_id(s15_rsp_id), .busy(s15_busy), .lookup_cnt(s15_cnt));

  // narrow-counter variant
  logic [3:0]  c_valid, c4_rdy;
  logic        c_ready;
  logic [7:0]  c4_pla_x;
  logic [62:0] c4_pla_z, c4_rsp_z;
  logic        c4_rsp_valid, c4_busy;
  logic [1:0]  c4_rsp_id;
  logic [3:0]  c4_cnt;
  assign c4_pla_z = pla_model(c4_pla_x);

  pla_lookup_arbiter #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_ready(c4_rdy), .req_x(a_x),
    .pla_x(c4_pla_x), .pla_z(c4_pla_z), .rsp_valid(c4_rsp_valid), .rsp_ready(c_ready),
    .rsp_z(c4_rsp_z), .rsp_id(c4_rsp_id), .busy(c4_busy), .lookup_cnt(c4_cnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("rsp_wait_bound", 64'(rsp_valid), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_pla_x"}, 64'(pla_x), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_z"}, 64'(rsp_z), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_lookup_cnt"}, 64'(lookup_cnt), 64'd0);
  endtask

  logic [1:0] exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] ops [4] = '{8'h10, 8'h21, 8'h42, 8'h83};

  initial begin
    int w, first0, first15, hs, cyc;
    logic stable;
    logic [62:0] held_z;
    req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    a_valid = '0; a_x = '0; a_ready = 1'b0;
    c_valid = '0; c_ready = 1'b0;

    // reset state
    #12;
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    step();

    // single lookup from requester 0, operand 0x00
    req_valid = 4'b0001; req_x[7:0] = 8'h00;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk("t1_pla_x", 64'(pla_x), 64'h00);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_req_ready_settle", 64'(req_ready), 64'd0);
    step();
    chk("t1_valid_t1", 64'(rsp_valid), 64'd0);
    step();
    chk("t1_valid_t2", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_z", 64'(rsp_z), 64'(pla_model(8'h00)));
    chk("t1_z01_z00", 64'(rsp_z[1:0]), 64'h3);
    chk("t1_rsp_id", 64'(rsp_id), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_valid_drop", 64'(rsp_valid), 64'd0);
    chk("t1_lookup_cnt", 64'(lookup_cnt), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);

    // reset again so the rotation starts from requester 0
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset2");
    step();
    rst_n = 1'b1;
    step();

    // all four requesting, rsp_ready high: rotation 0,1,2,3,0,1
    req_x = {ops[3], ops[2], ops[1], ops[0]};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_rsp(w);
      chk("t2_spacing", 64'(w), 64'd3);
      chk("t2_rsp_id", 64'(rsp_id), 64'(exp_id[n]));
      chk("t2_rsp_z", 64'(rsp_z), 64'(pla_model(ops[exp_id[n]])));
      if (n == 5) req_valid = '0;
      step();
    end
    rsp_ready = 1'b0;
    chk("t2_lookup_cnt", 64'(lookup_cnt), 64'd6);

    // back-pressure: response held, no grants while stalled
    req_valid = 4'b0100; req_x[23:16] = 8'h5C;
    wait_rsp(w);
    chk("t3_rsp_id", 64'(rsp_id), 64'd2);
    held_z = rsp_z;
    chk("t3_rsp_z", 64'(held_z), 64'(pla_model(8'h5C)));
    req_valid = 4'b0001; req_x[7:0] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t3_hold_z", 64'(rsp_z), 64'(held_z));
      chk("t3_hold_id", 64'(rsp_id), 64'd2);
      chk("t3_hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_release", 64'(rsp_valid), 64'd0);
    chk("t3_bubble_grant", 64'(req_ready), 64'h1);
    chk("t3_bubble_busy", 64'(busy), 64'd0);
    step();
    req_valid = '0;
    chk("t3_next_accept", 64'(busy), 64'd1);
    chk("t3_next_pla_x", 64'(pla_x), 64'h99);
    wait_rsp(w);
    chk("t3_next_id", 64'(rsp_id), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset during SETTLE discards the lookup and rewinds the pointer
    req_valid = 4'b0001; req_x[7:0] = 8'h77;
    step();
    req_valid = '0;
    chk("t4_in_settle", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t4_async");
    #2;
    rst_n = 1'b1;
    req_valid = 4'b0101; req_x[23:16] = 8'h31;
    #1;
    chk("t4_grant_req0", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    wait_rsp(w);
    chk("t4_rsp_id", 64'(rsp_id), 64'd0);
    chk("t4_rsp_z", 64'(rsp_z), 64'(pla_model(8'h77)));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // settle extremes: 0 and 15
    a_x[15:8] = 8'hE7;
    a_valid = 4'b0010;
    step();
    a_valid = '0;
    chk("t5_s0_early", 64'(s0_rsp_valid), 64'd0);
    chk("t5_s15_early", 64'(s15_rsp_valid), 64'd0);
    first0 = 0; first15 = 0; stable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (s0_rsp_valid && first0 == 0) first0 = k;
      if (s15_rsp_valid && first15 == 0) first15 = k;
      if (s0_pla_x !== 8'hE7 || s15_pla_x !== 8'hE7) stable = 1'b0;
    end
    chk("t5_s0_latency", 64'(first0), 64'd1);
    chk("t5_s15_latency", 64'(first15), 64'd16);
    chk("t5_pla_x_stable", 64'(stable), 64'd1);
    chk("t5_s15_rsp_z", 64'(s15_rsp_z), 64'(pla_model(8'hE7)));
    chk("t5_s0_rsp_id", 64'(s0_rsp_id), 64'd1);
    chk("t5_s15_rsp_id", 64'(s15_rsp_id), 64'd1);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    chk("t5_s15_done", 64'(s15_rsp_valid), 64'd0);

    // 20 back-to-back lookups on a 4-bit counter saturate at 15
    c_valid = 4'b1111;
    c_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 20 && cyc < 300) begin
      if (c4_rsp_valid) hs++;
      if (hs == 20) c_valid = '0;
      step();
      cyc++;
    end
    chk("t6_handshakes", 64'(hs), 64'd20);
    chk("t6_cnt_sat", 64'(c4_cnt), 64'hF);
    step(); step(); step();
    chk("t6_cnt_hold", 64'(c4_cnt), 64'hF);
    chk("t6_idle", 64'(c4_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pla_lookup_arbiter.md
Name: pla_lookup_arbiter

Overview:
- Shares one combinational 8-in/63-out PLA lookup block between NUM_REQ requesters.
- Round-robin arbitration, one lookup in flight at a time.
- Registers the PLA input vector, waits a programmable settle time, captures the 63-bit result and returns it with the requester ID over a valid/ready response channel.
- Sits between requester ports and the PLA instance. The PLA itself is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ID_W, 2, response ID width, equal to max(1, clog2(NUM_REQ)).
- IN_W, 8, PLA input width.
- OUT_W, 63, PLA output width.
- SETTLE_CYCLES, 1, extra cycles pla_x is held before capture (0..15).
- CNT_W, 16, width of the completed-lookup counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_x  in  NUM_REQ*IN_W  operands; requester i occupies bits [i*IN_W +: IN_W].
- pla_x  out  IN_W  registered drive to PLA inputs x7..x0.
- pla_z  in  OUT_W  PLA outputs z62..z00.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_z  out  OUT_W  captured PLA result.
- rsp_id  out  ID_W  index of the requester served.
- busy  out  1  high whenever state is not IDLE.
- lookup_cnt  out  CNT_W  completed responses, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: req_ready=0, pla_x=0, rsp_valid=0, rsp_z=0, rsp_id=0, busy=0, lookup_cnt=0, rr_ptr=0, state=IDLE, settle counter=0.
- State machine has three states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = one-hot, first asserted req_valid searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready = grant, combinational. This is the only state where req_ready may be nonzero.
  - On a clock edge with any req_valid: pla_x<=req_x[g], rsp_id<=g, rr_ptr<=(g+1) mod NUM_REQ, cnt<=SETTLE_CYCLES, state<=SETTLE.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- SETTLE:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: rsp_z<=pla_z, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_z and rsp_id are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid<=0, lookup_cnt<=lookup_cnt+1 (held at all-ones once reached), state<=IDLE.
  - No new request is accepted in the same cycle; there is always one IDLE bubble.
- Latency:
  - Acceptance edge T; rsp_valid high after edge T+1+SETTLE_CYCLES.
  - Minimum issue-to-issue spacing is SETTLE_CYCLES+3 cycles with rsp_ready tied high.
- pla_x holds its last operand after completion and changes only on an acceptance edge, so the PLA inputs never glitch.
- req_valid dropping before acceptance is legal and has no effect. req_x is sampled only on the acceptance edge.
- Fairness: each continuously-valid requester is served within NUM_REQ grants.
- Asserting rst_n low mid-operation, in any state, forces all reset values immediately. The in-flight request is discarded and the requester must reissue it. rr_ptr returns to 0.
- rsp_ready high while rsp_valid is low is ignored.
- busy = (state != IDLE), registered-state decode.

Test Plan:
- req_valid=0001, req_x[0]=0x00, SETTLE_CYCLES=1:
  - req_ready=0001 in the accept cycle.
  - pla_x=0x00.
  - rsp_valid rises 2 edges later.
  - rsp_z=pla_z model, with z00=1 and z01=1.
  - rsp_id=0, lookup_cnt=1.
- All four req_valid held high, rsp_ready=1, operands 0x10/0x21/0x42/0x83 -> rsp_id sequence 0,1,2,3,0,1. Each rsp_z matches the model for its operand.
- rsp_ready low for 5 cycles in RESP -> rsp_z and rsp_id constant; req_ready=0 throughout. After rsp_ready, the first new accept comes 1 cycle later.
- rst_n pulsed low during SETTLE -> all outputs at reset values asynchronously. Next request from req 2 with req 0 also valid: req 0 is served first.
- SETTLE_CYCLES=0 and =15 -> rsp_valid after edges T+1 and T+16 respectively; pla_x stable across the whole window.
- CNT_W=4, 20 back-to-back lookups -> lookup_cnt=15 and stays at 15.
